// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// ---------------
// Write-back controller and hazard scoreboard for the 32x32 register file.
// Two producers share the single register-file write port: EXU (port A,
// single-cycle results) and LSU (port B, multi-cycle loads).  A round-robin
// arbiter grants one of them per cycle.  The winner is registered onto the
// write port.  A busy vector tracks registers that have an outstanding
// producer, so decode can stall on RAW/WAW hazards.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   iss_valid                    decode presents an instruction
//   iss_rs1/iss_rs2              source indices
//   iss_use_rs1/iss_use_rs2      source is actually read
//   iss_wr/iss_rd                instruction writes iss_rd
//   iss_stall                    combinational: instruction must not issue
//   a_valid/a_ready/a_rd/a_data  EXU write-back handshake
//   b_valid/b_ready/b_rd/b_data  LSU write-back handshake
//   rf_wen/rf_waddr/rf_wdata     registered register-file write port
//   busy                         scoreboard vector (bit 0 always 0)
//   err_spurious                 sticky: write-back to a non-busy register
module regfile_wb_ctrl #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    iss_valid,
   input  logic [$clog2(NREG)-1:0] iss_rs1,
   input  logic [$clog2(NREG)-1:0] iss_rs2,
   input  logic                    iss_use_rs1,
   input  logic                    iss_use_rs2,
   input  logic                    iss_wr,
   input  logic [$clog2(NREG)-1:0] iss_rd,
   output logic                    iss_stall,
   input  logic                    a_valid,
   output logic                    a_ready,
   input  logic [$clog2(NREG)-1:0] a_rd,
   input  logic [XLEN-1:0]         a_data,
   input  logic                    b_valid,
   output logic                    b_ready,
   input  logic [$clog2(NREG)-1:0] b_rd,
   input  logic [XLEN-1:0]         b_data,
   output logic                    rf_wen,
   output logic [$clog2(NREG)-1:0] rf_waddr,
   output logic [XLEN-1:0]         rf_wdata,
   output logic [NREG-1:0]         busy,
   output logic                    err_spurious
);

   localparam int AW = $clog2(NREG);

   logic [NREG-1:0] busy_q,   busy_d;
   logic            lg_q,     lg_d;
   logic            wen_q,    wen_d;
   logic [AW-1:0]   waddr_q,  waddr_d;
   logic [XLEN-1:0] wdata_q,  wdata_d;
   logic            err_q,    err_d;

   logic            xfer_s;
   logic [AW-1:0]   sel_rd_s;
   logic [XLEN-1:0] sel_data_s;
   logic            iss_fire_s;

   // Round-robin grant: lg_q=1 means B won last, so A takes a tie.
   always_comb begin
      a_ready = a_valid & (~b_valid | lg_q);
      b_ready = b_valid & (~a_valid | ~lg_q);
   end

   // Hazard stall on current scoreboard state only (no write-back bypass).
   always_comb begin
      iss_stall = iss_valid & ((iss_use_rs1 & busy_q[iss_rs1]) |
                               (iss_use_rs2 & busy_q[iss_rs2]) |
                               (iss_wr      & busy_q[iss_rd]));
   end

   // Winning transfer selection and next-state for all registered state.
   always_comb begin
      xfer_s     = a_ready | b_ready;
      sel_rd_s   = a_ready ? a_rd   : b_rd;
      sel_data_s = a_ready ? a_data : b_data;
      iss_fire_s = iss_valid & ~iss_stall & iss_wr & (iss_rd != {AW{1'b0}});

      // last-grant tracks whoever won this cycle, else holds
      if (a_ready) begin
         lg_d = 1'b0;
      end else if (b_ready) begin
         lg_d = 1'b1;
      end else begin
         lg_d = lg_q;
      end

      // writes to x0 complete the handshake but never reach the port
      wen_d = xfer_s & (sel_rd_s != {AW{1'b0}});
      if (wen_d) begin
         waddr_d = sel_rd_s;
         wdata_d = sel_data_s;
      end else begin
         waddr_d = waddr_q;
         wdata_d = wdata_q;
      end

      // a real write-back must target a register with a pending producer
      if (wen_d & ~busy_q[sel_rd_s]) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end

      // clear from the write port first so a same-index set wins
      busy_d = busy_q;
      if (wen_q) begin
         busy_d[waddr_q] = 1'b0;
      end else begin
         busy_d = busy_d;
      end
      if (iss_fire_s) begin
         busy_d[iss_rd] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      busy_d[0] = 1'b0;
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= {NREG{1'b0}};
         lg_q    <= 1'b1;
         wen_q   <= 1'b0;
         waddr_q <= {AW{1'b0}};
         wdata_q <= {XLEN{1'b0}};
         err_q   <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         lg_q    <= lg_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   assign rf_wen       = wen_q;
   assign rf_waddr     = waddr_q;
   assign rf_wdata     = wdata_q;
   assign busy         = busy_q;
   assign err_spurious = err_q;

endmodule
